id_issue_scoreboard: RTL and testbench

- Parametrised successor to the decode-stage issue logic.
- Registers decoded instructions into the ID/EX slot under a valid/ready handshake.
- Tracks outstanding long-latency register writes (loads, divides) in a per-register pending-count scoreboard; this replaces the fixed one-cycle load-use check.
- Produces forwarding selects for a configurable number of downstream stages.
- Sits between the decoder/regfile read and the EX stage.

---
 rtl/id_issue_scoreboard.sv | 127 ++++++++++++
 tb/tb_id_issue_scoreboard.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/id_issue_scoreboard.sv
// Decode-stage issue slot: ID/EX register with valid/ready handshake, a per-register
// pending-count scoreboard for long-latency writes, and forwarding selects for downstream stages.
module id_issue_scoreboard #(
    parameter int NREG      = 32,
    parameter int RID_W     = $clog2(NREG),
    parameter int PAYLOAD_W = 128,
    parameter int FWD_DEPTH = 2,
    parameter int PEND_W    = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [RID_W-1:0]           in_rs1,
    input  logic [RID_W-1:0]           in_rs2,
    input  logic                       in_rs1_rd,
    input  logic                       in_rs2_rd,
    input  logic [RID_W-1:0]           in_rd,
    input  logic                       in_wr,
    input  logic                       in_long,
    input  logic [PAYLOAD_W-1:0]       in_payload,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [PAYLOAD_W-1:0]       out_payload,
    output logic [RID_W-1:0]           out_rd,
    output logic                       out_wr,
    output logic                       out_long,
    output logic [FWD_DEPTH-1:0]       out_fwd1,
    output logic [FWD_DEPTH-1:0]       out_fwd2,
    input  logic [FWD_DEPTH*RID_W-1:0] stage_rd,
    input  logic [FWD_DEPTH-1:0]       stage_wr,
    input  logic                       lw_valid,
    input  logic [RID_W-1:0]           lw_rd,
    input  logic                       kill_valid,
    input  logic [RID_W-1:0]           kill_rd
);

    logic [PEND_W-1:0] pend     [NREG];
    logic [PEND_W-1:0] pend_nxt [NREG];
    logic [NREG-1:0]   underflow;

    logic [RID_W-1:0] slot_rs1, slot_rs2;
    logic             slot_rs1_rd, slot_rs2_rd;
    logic             haz, accept, undo;

    always_comb begin
        haz = (in_rs1_rd && in_rs1 != '0 && pend[in_rs1] != '0)
           || (in_rs2_rd && in_rs2 != '0 && pend[in_rs2] != '0)
           || (in_wr && in_long && in_rd != '0 && (&pend[in_rd]));
    end

    assign in_ready = ~flush & ~haz & (~out_valid | out_ready);
    assign accept   = in_valid & in_ready;
    // A flushed long op never completes, so its reservation is returned here.
    assign undo     = flush & out_valid & out_wr & out_long;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid   <= 1'b0;
            out_payload <= '0;
            out_rd      <= '0;
            out_wr      <= 1'b0;
            out_long    <= 1'b0;
            slot_rs1    <= '0;
            slot_rs2    <= '0;
            slot_rs1_rd <= 1'b0;
            slot_rs2_rd <= 1'b0;
        end else if (accept) begin
            out_valid   <= 1'b1;
            out_payload <= in_payload;
            out_rd      <= in_rd;
            out_wr      <= in_wr;
            out_long    <= in_long;
            slot_rs1    <= in_rs1;
            slot_rs2    <= in_rs2;
            slot_rs1_rd <= in_rs1_rd;
            slot_rs2_rd <= in_rs2_rd;
        end else if (out_ready || flush) begin
            out_valid   <= 1'b0;
        end
    end

    always_comb begin
        for (int r = 0; r < NREG; r++) begin
            logic                inc;
            logic [1:0]          dec;
            logic [PEND_W+1:0]   sum;
            inc = accept && in_wr && in_long && in_rd == RID_W'(r);
            dec = 2'(lw_valid && lw_rd == RID_W'(r))
                + 2'(kill_valid && kill_rd == RID_W'(r))
                + 2'(undo && out_rd == RID_W'(r));
            sum = (PEND_W+2)'(pend[r]) + (PEND_W+2)'(inc);
            underflow[r] = (r != 0) && (sum < (PEND_W+2)'(dec));
            if (r == 0 || underflow[r])
                pend_nxt[r] = '0;
            else
                pend_nxt[r] = PEND_W'(sum - (PEND_W+2)'(dec));
        end
    end

    always_ff @(posedge clk) begin
        for (int r = 0; r < NREG; r++)
            pend[r] <= rst ? '0 : pend_nxt[r];
        if (!rst)
            assert (underflow == '0);
    end

    // Lowest stage index is the youngest producer, so it is evaluated last and wins.
    always_comb begin
        out_fwd1 = '0;
        out_fwd2 = '0;
        for (int k = FWD_DEPTH-1; k >= 0; k--) begin
            if (stage_wr[k] && stage_rd[k*RID_W +: RID_W] == slot_rs1) begin
                out_fwd1    = '0;
                out_fwd1[k] = 1'b1;
            end
            if (stage_wr[k] && stage_rd[k*RID_W +: RID_W] == slot_rs2) begin
                out_fwd2    = '0;
                out_fwd2[k] = 1'b1;
            end
        end
        if (!(out_valid && slot_rs1_rd && slot_rs1 != '0)) out_fwd1 = '0;
        if (!(out_valid && slot_rs2_rd && slot_rs2 != '0)) out_fwd2 = '0;
    end

endmodule

// File: tb/tb_id_issue_scoreboard.sv
// Directed bench for id_issue_scoreboard: load-use stall, forwarding priority,
// saturation, flush undo, simultaneous scoreboard events and backpressure.
module tb_id_issue_scoreboard;

    logic         clk = 1'b0;
    logic         rst, flush, in_valid, in_ready;
    logic [4:0]   in_rs1, in_rs2, in_rd;
    logic         in_rs1_rd, in_rs2_rd, in_wr, in_long;
    logic [127:0] in_payload, out_payload;
    logic         out_valid, out_ready, out_wr, out_long;
    logic [4:0]   out_rd;
    logic [1:0]   out_fwd1, out_fwd2, stage_wr;
    logic [9:0]   stage_rd;
    logic         lw_valid, kill_valid;
    logic [4:0]   lw_rd, kill_rd;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    id_issue_scoreboard dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rs1_rd(in_rs1_rd), .in_rs2_rd(in_rs2_rd),
        .in_rd(in_rd), .in_wr(in_wr), .in_long(in_long), .in_payload(in_payload),
        .out_valid(out_valid), .out_ready(out_ready), .out_payload(out_payload),
        .out_rd(out_rd), .out_wr(out_wr), .out_long(out_long),
        .out_fwd1(out_fwd1), .out_fwd2(out_fwd2),
        .stage_rd(stage_rd), .stage_wr(stage_wr),
        .lw_valid(lw_valid), .lw_rd(lw_rd),
        .kill_valid(kill_valid), .kill_rd(kill_rd)
    );

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [4:0] rs1, input logic r1, input logic [4:0] rs2,
                         input logic r2, input logic [4:0] rd, input logic wr,
                         input logic lng, input logic [127:0] pl);
        in_valid = 1'b1;
        in_rs1 = rs1; in_rs1_rd = r1; in_rs2 = rs2; in_rs2_rd = r2;
        in_rd = rd; in_wr = wr; in_long = lng; in_payload = pl;
        #1;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_rs1 = '0; in_rs2 = '0; in_rs1_rd = 1'b0; in_rs2_rd = 1'b0;
        in_rd = '0; in_wr = 1'b0; in_long = 1'b0; in_payload = '0;
        stage_rd = '0; stage_wr = '0;
        lw_valid = 1'b0; lw_rd = '0; kill_valid = 1'b0; kill_rd = '0;
        tick(); tick();
        rst = 1'b0;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_payload", out_payload, 0);
        chk("rst_out_rd", out_rd, 0);
        chk("rst_out_wr", out_wr, 0);
        chk("rst_out_long", out_long, 0);
        chk("rst_in_ready", in_ready, 1);

        // long load rd=5, then consumer of x5
        drive(5'd1, 1'b1, 5'd2, 1'b1, 5'd5, 1'b1, 1'b1, 128'hA5);
        chk("ld_accept_ready", in_ready, 1);
        tick();
        chk("ld_pend5_1", dut.pend[5], 1);
        chk("ld_out_rd", out_rd, 5);
        chk("ld_out_long", out_long, 1);
        drive(5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 1'b0, 128'hC0);
        chk("use_stall0", in_ready, 0);
        tick();
        chk("use_stall1", in_ready, 0);
        chk("use_slot_empty", out_valid, 0);
        lw_valid = 1'b1; lw_rd = 5'd5; #1;
        chk("use_stall_lw_cycle", in_ready, 0);
        tick();
        lw_valid = 1'b0; #1;
        chk("use_pend5_0", dut.pend[5], 0);
        chk("use_release", in_ready, 1);
        tick();
        chk("use_loaded", out_payload, 128'hC0);
        chk("use_out_rd", out_rd, 6);
        in_valid = 1'b0;
        tick();

        // forwarding priority
        drive(5'd7, 1'b1, 5'd0, 1'b0, 5'd8, 1'b1, 1'b0, 128'hF1);
        tick();
        in_valid = 1'b0; out_ready = 1'b0;
        stage_rd = {5'd7, 5'd7}; stage_wr = 2'b11; #1;
        chk("fwd1_both", out_fwd1, 2'b01);
        chk("fwd2_none", out_fwd2, 2'b00);
        stage_wr = 2'b10; #1;
        chk("fwd1_old", out_fwd1, 2'b10);
        out_ready = 1'b1;
        drive(5'd0, 1'b1, 5'd7, 1'b1, 5'd8, 1'b1, 1'b0, 128'hF2);
        tick();
        in_valid = 1'b0; out_ready = 1'b0; stage_wr = 2'b11; #1;
        chk("fwd1_x0", out_fwd1, 2'b00);
        chk("fwd2_both", out_fwd2, 2'b01);
        out_ready = 1'b1; stage_wr = 2'b00;
        tick();

        // saturation on x3
        drive(5'd1, 1'b0, 5'd2, 1'b0, 5'd3, 1'b1, 1'b1, 128'h33);
        for (int i = 0; i < 3; i++) begin
            chk("sat_accept", in_ready, 1);
            tick();
        end
        chk("sat_pend3_max", dut.pend[3], 3);
        chk("sat_stall", in_ready, 0);
        lw_valid = 1'b1; lw_rd = 5'd3; #1;
        chk("sat_stall_lw_cycle", in_ready, 0);
        tick();
        lw_valid = 1'b0; #1;
        chk("sat_pend3_2", dut.pend[3], 2);
        chk("sat_release", in_ready, 1);
        tick();
        in_valid = 1'b0; #1;
        chk("sat_pend3_refill", dut.pend[3], 3);
        lw_valid = 1'b1;
        tick(); tick(); tick();
        lw_valid = 1'b0; #1;
        chk("sat_drained", dut.pend[3], 0);

        // flush undo
        out_ready = 1'b0;
        drive(5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1, 1'b1, 128'h99);
        tick();
        chk("fl_pend9_1", dut.pend[9], 1);
        drive(5'd1, 1'b0, 5'd0, 1'b0, 5'd10, 1'b1, 1'b0, 128'hAA);
        flush = 1'b1; #1;
        chk("fl_no_accept", in_ready, 0);
        tick();
        flush = 1'b0; in_valid = 1'b0; #1;
        chk("fl_out_valid", out_valid, 0);
        chk("fl_pend9_0", dut.pend[9], 0);
        out_ready = 1'b1;

        // simultaneous events on x4
        drive(5'd0, 1'b0, 5'd0, 1'b0, 5'd4, 1'b1, 1'b1, 128'h44);
        tick();
        chk("sim_pend4_1", dut.pend[4], 1);
        lw_valid = 1'b1; lw_rd = 5'd4; #1;
        chk("sim_ready", in_ready, 1);
        tick();
        chk("sim_inc_dec", dut.pend[4], 1);
        kill_valid = 1'b1; kill_rd = 5'd4; #1;
        tick();
        in_valid = 1'b0; lw_valid = 1'b0; kill_valid = 1'b0; #1;
        chk("sim_inc_dec_kill", dut.pend[4], 0);
        tick();

        // backpressure hold
        drive(5'd0, 1'b0, 5'd0, 1'b0, 5'd11, 1'b1, 1'b0, 128'hBEEF_0001);
        tick();
        out_ready = 1'b0;
        drive(5'd0, 1'b0, 5'd0, 1'b0, 5'd12, 1'b1, 1'b0, 128'hBEEF_0002);
        for (int i = 0; i < 3; i++) begin
            chk("bp_stall", in_ready, 0);
            chk("bp_hold", out_payload, 128'hBEEF_0001);
            tick();
        end
        out_ready = 1'b1; #1;
        chk("bp_ready", in_ready, 1);
        tick();
        in_valid = 1'b0;
        chk("bp_loaded", out_payload, 128'hBEEF_0002);
        chk("bp_out_rd", out_rd, 12);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
